// File: rtl/my_rgb2gray_mul_sched.sv
// RGB888 to 8-bit gray conversion with a single shared 8x22 multiplier,
// sequenced R, G, B over three cycles, with run-time programmable coefficients.
`timescale 1ns/1ps
module my_rgb2gray_mul_sched #(
  parameter int          FRAC_BITS   = 20,
  parameter logic [21:0] COEF_R_INIT = 22'd313524,
  parameter logic [21:0] COEF_G_INIT = 22'd615514,
  parameter logic [21:0] COEF_B_INIT = 22'd119538
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic [23:0] s_pix_data,
  input  logic        s_pix_last,
  input  logic        s_pix_valid,
  output logic        s_pix_ready,
  output logic [7:0]  m_gray_data,
  output logic        m_gray_last,
  output logic        m_gray_valid,
  input  logic        m_gray_ready,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [21:0] cfg_coef,
  output logic        busy
);

  // 8x22 product needs 30 bits; three of them plus the rounding bias need 32
  // bits so the accumulation can never wrap, whatever coefficients are loaded.
  localparam int PROD_W = 30;
  localparam int ACC_W  = 32;

  typedef enum logic [2:0] {IDLE, MR, MG, MB, OUT} state_t;

  state_t            state;
  logic [7:0]        pix_r, pix_g, pix_b;
  logic              pix_last;
  logic [21:0]       shd_r, shd_g, shd_b;
  logic [21:0]       act_r, act_g, act_b;
  logic [21:0]       new_r, new_g, new_b;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [7:0]        mul_a;
  logic [21:0]       mul_b;
  logic [PROD_W-1:0] prod;
  logic              rdy_q;

  function automatic logic [ACC_W-1:0] round_bias();
    return ACC_W'(1) << (FRAC_BITS - 1);
  endfunction

  function automatic logic [7:0] sat_gray(input logic [ACC_W-1:0] s);
    logic [ACC_W-1:0] q;
    q = s >> FRAC_BITS;
    if (q > ACC_W'(255))
      return 8'hFF;
    return q[7:0];
  endfunction

  // A same-edge write is forwarded so a pixel accepted on that edge sees it.
  assign new_r = (cfg_we && cfg_sel == 2'd0) ? cfg_coef : shd_r;
  assign new_g = (cfg_we && cfg_sel == 2'd1) ? cfg_coef : shd_g;
  assign new_b = (cfg_we && cfg_sel == 2'd2) ? cfg_coef : shd_b;

  always_comb begin
    mul_a = pix_b;
    mul_b = act_b;
    unique case (state)
      MR:      begin mul_a = pix_r; mul_b = act_r; end
      MG:      begin mul_a = pix_g; mul_b = act_g; end
      default: begin mul_a = pix_b; mul_b = act_b; end
    endcase
  end

  assign prod = PROD_W'(mul_a) * PROD_W'(mul_b);
  assign sum  = acc + ACC_W'(prod);

  assign s_pix_ready = rdy_q;
  assign busy        = (state != IDLE);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state        <= IDLE;
      rdy_q        <= 1'b0;
      acc          <= '0;
      pix_r        <= '0;
      pix_g        <= '0;
      pix_b        <= '0;
      pix_last     <= 1'b0;
      shd_r        <= COEF_R_INIT;
      shd_g        <= COEF_G_INIT;
      shd_b        <= COEF_B_INIT;
      act_r        <= COEF_R_INIT;
      act_g        <= COEF_G_INIT;
      act_b        <= COEF_B_INIT;
      m_gray_data  <= '0;
      m_gray_last  <= 1'b0;
      m_gray_valid <= 1'b0;
    end else begin
      shd_r <= new_r;
      shd_g <= new_g;
      shd_b <= new_b;
      unique case (state)
        IDLE: begin
          if (s_pix_valid && rdy_q) begin
            pix_r    <= s_pix_data[23:16];
            pix_g    <= s_pix_data[15:8];
            pix_b    <= s_pix_data[7:0];
            pix_last <= s_pix_last;
            act_r    <= new_r;
            act_g    <= new_g;
            act_b    <= new_b;
            acc      <= round_bias();
            rdy_q    <= 1'b0;
            state    <= MR;
          end else begin
            rdy_q    <= 1'b1;
          end
        end
        MR: begin
          acc   <= sum;
          state <= MG;
        end
        MG: begin
          acc   <= sum;
          state <= MB;
        end
        MB: begin
          m_gray_data  <= sat_gray(sum);
          m_gray_last  <= pix_last;
          m_gray_valid <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (m_gray_ready) begin
            m_gray_valid <= 1'b0;
            rdy_q        <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          rdy_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
